// File: rtl/mem_port_ctrl_pkg.sv
// mem_port_ctrl_pkg
//   Shared definitions for the memory port controller: load/store opcode
//   values, FSM state encoding, requester grant encoding and small opcode
//   classification helpers.
package mem_port_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/mem_port_ctrl_lane_fmt.sv
// mem_lane_fmt
//   Combinational data formatter between the CPU and the 32-bit RAM.
//   op        : load/store opcode
//   addr_lo   : byte offset within the word
//   wdata     : right-justified store data
//   rdata     : raw RAM word
//   be        : byte enables (zero for loads and unknown opcodes)
//   wdata_rep : store data replicated across all lanes
//   rdata_ext : selected and sign/zero-extended load data
//   misalign  : access not naturally aligned for its size
module mem_lane_fmt
  import mem_port_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  always_comb begin
    be        = 4'h0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (op)
      OP_SW: begin
        be       = 4'hf;
        misalign = (addr_lo != 2'd0);
      end
      OP_LW: misalign = (addr_lo != 2'd0);
      OP_SH: begin
        be        = addr_lo[1] ? 4'hc : 4'h3;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      OP_LH: begin
        rdata_ext = {{16{half_sel[15]}}, half_sel};
        misalign  = addr_lo[0];
      end
      OP_LHU: begin
        rdata_ext = {16'h0000, half_sel};
        misalign  = addr_lo[0];
      end
      OP_SB: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      OP_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: rdata_ext = {24'h000000, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
//   Shares one synchronous single-port RAM between instruction fetch (IF)
//   and the MEM stage with round-robin arbitration.
//   clk/rstn              : clock, synchronous active-low reset
//   if_req/if_addr        : fetch request; if_rdata/if_done response
//   mem_req/op/addr/wdata : load/store request
//   mem_rdata/mem_done/mem_misalign : load/store response
//   busy                  : controller not idle
//   ram_*                 : RAM port (read data one cycle after ram_en)
//
// state | meaning
// IDLE  | sample requests, grant, launch RAM strobe or reject
// ACC   | RAM strobe active for exactly one cycle
// RESP  | RAM read data valid, capture and format it
// DONE  | done pulse visible, record last grant
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic [5:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_misalign,
  output logic              busy,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e            state_q, state_d;
  grant_e            last_q, last_d, gnt_q, gnt_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              misalign_q, misalign_d, busy_q, busy_d;
  logic              take_mem;

  logic [5:0]  fmt_op;
  logic [1:0]  fmt_addr;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_rdata;
  logic        fmt_misalign;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                              mem_addr[31:RAM_AW+2]};

  // The formatter sees the live request while idle (to launch the strobe at
  // the grant edge) and the snapshot afterwards (to extract load data).
  assign fmt_op   = (state_q == ST_IDLE) ? mem_op : op_q;
  assign fmt_addr = (state_q == ST_IDLE) ? mem_addr[1:0] : addr_lo_q;

  mem_lane_fmt u_lane_fmt (
    .op        (fmt_op),
    .addr_lo   (fmt_addr),
    .wdata     (mem_wdata),
    .rdata     (ram_rdata),
    .be        (fmt_be),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .misalign  (fmt_misalign)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'h0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    misalign_d  = 1'b0;
    take_mem    = mem_req && (!if_req || (last_q == GNT_IF));

    case (state_q)
      ST_IDLE: begin
        if (take_mem) begin
          gnt_d     = GNT_MEM;
          op_d      = mem_op;
          addr_lo_d = mem_addr[1:0];
          if (fmt_misalign || !(op_is_load(mem_op) || op_is_store(mem_op))) begin
            state_d     = ST_DONE;
            mem_done_d  = 1'b1;
            misalign_d  = fmt_misalign;
            mem_rdata_d = 32'h0;
          end else begin
            state_d    = ST_ACC;
            ram_en_d   = 1'b1;
            ram_addr_d = mem_addr[RAM_AW+1:2];
            if (op_is_store(mem_op)) begin
              ram_we_d    = fmt_be;
              ram_wdata_d = fmt_wdata;
            end
          end
        end else if (if_req) begin
          gnt_d      = GNT_IF;
          state_d    = ST_ACC;
          ram_en_d   = 1'b1;
          ram_addr_d = if_addr[RAM_AW+1:2];
        end
      end
      ST_ACC: begin
        if ((gnt_q == GNT_MEM) && op_is_store(op_q)) begin
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_DONE;
        if (gnt_q == GNT_IF) begin
          if_rdata_d = ram_rdata;
          if_done_d  = 1'b1;
        end else begin
          mem_rdata_d = fmt_rdata;
          mem_done_d  = 1'b1;
        end
      end
      default: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_IF;
      gnt_q       <= GNT_IF;
      op_q        <= 6'h0;
      addr_lo_q   <= 2'h0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      misalign_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      misalign_q  <= misalign_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata     = if_rdata_q;
  assign if_done      = if_done_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_done     = mem_done_q;
  assign mem_misalign = misalign_q;
  assign busy         = busy_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;
  import mem_port_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, mem_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [5:0]  mem_op;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic        if_done, mem_done, mem_misalign, busy, ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ram [0:1023];
  logic [7:0]  ref_b [0:4095];

  mem_port_ctrl #(.RAM_AW(10)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_misalign(mem_misalign),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    int a  = int'(addr[11:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[a+i]) << (8*i));
    if ((op == OP_LB || op == OP_LH) && v[8*sz-1]) v = v | (32'hffffffff << (8*sz));
    return v;
  endfunction

  task automatic do_mem(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    int sz = op_size(op);
    logic st = (op == OP_SB || op == OP_SH || op == OP_SW);
    logic inv = (sz == 0);
    logic mis = !inv && (int'(addr[1:0]) % sz != 0);
    int exp_lat = (inv || mis) ? 1 : (st ? 2 : 3);
    int cyc = 0, en_cnt = 0;
    logic done_seen = 1'b0;
    logic [3:0]  we_seen = 4'h0;
    logic [31:0] wd_seen = 32'h0, exp_wd, exp_rd;
    logic [9:0]  ad_seen = 10'h0;
    exp_rd = ref_load(op, addr);
    exp_wd = (sz == 1) ? (wdata & 32'hff) * 32'h01010101 :
             (sz == 2) ? (wdata & 32'hffff) * 32'h00010001 : wdata;
    mem_req = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata;
    while (!done_seen && cyc < 20) begin
      tick();
      cyc++;
      if (ram_en) begin
        en_cnt++; we_seen = ram_we; wd_seen = ram_wdata; ad_seen = ram_addr;
      end
      if (mem_done) done_seen = 1'b1;
    end
    got = mem_rdata;
    chk("mem_done_seen", 32'(done_seen), 32'd1);
    chk("mem_latency", cyc, exp_lat);
    chk("mem_ram_en_cycles", en_cnt, (inv || mis) ? 0 : 1);
    chk("mem_misalign", 32'(mem_misalign), 32'(mis));
    if (inv || mis) chk("mem_reject_rdata", mem_rdata, 32'h0);
    else begin
      chk("mem_ram_addr", 32'(ad_seen), 32'(addr[11:2]));
      if (st) begin
        chk("mem_ram_we", 32'(we_seen), ((32'(1) << sz) - 1) << addr[1:0]);
        chk("mem_ram_wdata", wd_seen, exp_wd);
        for (int i = 0; i < sz; i++) ref_b[addr[11:0] + 12'(i)] = wdata[8*i +: 8];
      end else begin
        chk("mem_load_we", 32'(we_seen), 32'h0);
        chk("mem_rdata", mem_rdata, exp_rd);
      end
    end
    mem_req = 1'b0;
    tick();
    chk("mem_done_one_cycle", 32'(mem_done), 32'h0);
    chk("mem_idle_busy", 32'(busy), 32'h0);
  endtask

  task automatic do_if(input logic [31:0] addr);
    int cyc = 0, en_cnt = 0;
    logic done_seen = 1'b0;
    logic [3:0] we_seen = 4'h0;
    logic [9:0] ad_seen = 10'h0;
    if_req = 1'b1; if_addr = addr;
    while (!done_seen && cyc < 20) begin
      tick();
      cyc++;
      if (ram_en) begin en_cnt++; we_seen = ram_we; ad_seen = ram_addr; end
      if (if_done) done_seen = 1'b1;
    end
    chk("if_done_seen", 32'(done_seen), 32'd1);
    chk("if_latency", cyc, 3);
    chk("if_ram_en_cycles", en_cnt, 1);
    chk("if_ram_we", 32'(we_seen), 32'h0);
    chk("if_ram_addr", 32'(ad_seen), 32'(addr[11:2]));
    chk("if_rdata", if_rdata, ref_load(OP_LW, addr & 32'hfffffffc));
    if_req = 1'b0;
    tick();
    chk("if_done_one_cycle", 32'(if_done), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_dones"}, {30'h0, if_done, mem_done}, 0);
    chk({tag, "_misalign"}, 32'(mem_misalign), 0);
  endtask

  logic [5:0] op_tab [0:8];
  logic [31:0] r;
  int seq [0:3];
  int nseq, cyc, done_cnt;

  initial begin
    op_tab = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h3f};
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i+b] = ram[i][8*b +: 8];
    end
    rstn = 1'b0; if_req = 0; mem_req = 0;
    if_addr = 0; mem_addr = 0; mem_op = 0; mem_wdata = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rstn = 1'b1;

    // Contention straight after reset: MEM first, then alternate.
    if_req = 1; if_addr = 32'h20; mem_req = 1; mem_op = OP_LW; mem_addr = 32'h10;
    nseq = 0; cyc = 0;
    while (nseq < 4 && cyc < 60) begin
      tick(); cyc++;
      if (mem_done) begin
        seq[nseq] = 1; nseq++;
        chk("arb_mem_rdata", mem_rdata, ref_load(OP_LW, 32'h10));
      end
      if (if_done) begin
        seq[nseq] = 0; nseq++;
        chk("arb_if_rdata", if_rdata, ref_load(OP_LW, 32'h20));
      end
    end
    if_req = 0; mem_req = 0;
    chk("arb_grants_seen", nseq, 4);
    for (int k = 0; k < nseq; k++) chk("arb_order", seq[k], (k % 2 == 0) ? 1 : 0);
    repeat (2) tick();
    chk("arb_idle", 32'(busy), 0);

    do_mem(OP_SW, 32'h10, 32'hDEADBEEF, r);
    do_mem(OP_LW, 32'h10, 32'h0, r);   chk("plan_lw_10", r, 32'hDEADBEEF);
    do_mem(OP_SB, 32'h13, 32'hA5, r);
    do_mem(OP_LB, 32'h13, 32'h0, r);   chk("plan_lb_13", r, 32'hFFFFFFA5);
    do_mem(OP_LBU, 32'h13, 32'h0, r);  chk("plan_lbu_13", r, 32'h000000A5);
    do_mem(OP_SH, 32'h22, 32'h8001, r);
    do_mem(OP_LH, 32'h22, 32'h0, r);   chk("plan_lh_22", r, 32'hFFFF8001);
    do_mem(OP_LHU, 32'h22, 32'h0, r);  chk("plan_lhu_22", r, 32'h00008001);
    do_mem(OP_LW, 32'h42, 32'h0, r);
    do_mem(OP_SH, 32'h43, 32'h1234, r);
    do_mem(6'h3f, 32'h40, 32'h0, r);
    do_if(32'h10);

    // Reset during the access cycle of a store abandons it silently.
    mem_req = 1; mem_op = OP_SW; mem_addr = 32'hF00; mem_wdata = $urandom;
    tick();
    chk("rst_acc_ram_en", 32'(ram_en), 1);
    rstn = 0; mem_req = 0;
    tick();
    chk_all_zero("midrst");
    rstn = 1;
    done_cnt = 0;
    repeat (6) begin tick(); if (mem_done || if_done) done_cnt++; end
    chk("midrst_no_done", done_cnt, 0);

    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 4) == 0) do_if($urandom_range(0, 1023));
      else do_mem(op_tab[$urandom_range(0, 8)], $urandom_range(0, 1023), $urandom, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
